// File: rtl/dds_ctrl_pkg.sv
// Shared constants for the DDS sweep controller: FSM state encoding and
// configuration register select values.
package dds_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_LOAD_P = 3'd1;
  localparam state_t S_LOAD_F = 3'd2;
  localparam state_t S_DWELL  = 3'd3;
  localparam state_t S_DONE   = 3'd4;

  localparam logic [2:0] A_F_START = 3'd0;
  localparam logic [2:0] A_F_STEP  = 3'd1;
  localparam logic [2:0] A_N_STEPS = 3'd2;
  localparam logic [2:0] A_DWELL   = 3'd3;
  localparam logic [2:0] A_PHASE   = 3'd4;

endpackage

// File: rtl/dds_sweep_ctrl_dwell_timer.sv
// Dwell down-counter: loaded with the dwell length, counts down while
// enabled, and flags the final cycle of the dwell period.
module dds_dwell_timer #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic                 i_en,
  input  logic [CNT_WIDTH-1:0] i_value,
  output logic                 o_expire
);

  logic [CNT_WIDTH-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_WIDTH'(1);
    end
  end

  assign o_expire = (r_cnt == CNT_WIDTH'(1));

endmodule

// File: rtl/dds_sweep_ctrl.sv
// DDS frequency sweep controller: loads phase, then steps the frequency word
// n_steps+1 times with a programmable dwell between loads.
module dds_sweep_ctrl
  import dds_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic [2:0]            cfg_addr,
  input  logic [DATA_WIDTH-1:0] cfg_data,
  input  logic                  start,
  input  logic                  abort,
  output logic                  Enable,
  output logic                  LoadP,
  output logic                  LoadF,
  output logic [DATA_WIDTH-1:0] FreqPhase,
  output logic                  busy,
  output logic                  done
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_f_start;
  logic [DATA_WIDTH-1:0] r_f_step;
  logic [DATA_WIDTH-1:0] r_phase;
  logic [CNT_WIDTH-1:0]  r_n_steps;
  logic [CNT_WIDTH-1:0]  r_dwell;
  logic [DATA_WIDTH-1:0] r_cur_freq;
  logic [CNT_WIDTH-1:0]  r_step_idx;
  logic [CNT_WIDTH-1:0]  w_dwell_len;
  logic                  w_expire;
  logic                  w_dwell_end;
  logic                  w_last;
  logic                  w_launch;
  logic                  w_advance;

  // A programmed dwell of 0 still yields one dwell cycle.
  assign w_dwell_len = (r_dwell == '0) ? CNT_WIDTH'(1) : r_dwell;

  dds_dwell_timer #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_dwell (
    .clk      (clk),
    .rst      (rst),
    .i_load   (r_state == S_LOAD_F),
    .i_en     (r_state == S_DWELL),
    .i_value  (w_dwell_len),
    .o_expire (w_expire)
  );

  assign w_dwell_end = (r_state == S_DWELL) && w_expire;
  assign w_last      = (r_step_idx == r_n_steps);
  assign w_launch    = (r_state == S_IDLE) && start && !abort;
  assign w_advance   = w_dwell_end && !w_last && !abort;

  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (start) w_state_nxt = S_LOAD_P;
        S_LOAD_P: w_state_nxt = S_LOAD_F;
        S_LOAD_F: w_state_nxt = S_DWELL;
        S_DWELL:  if (w_expire) w_state_nxt = w_last ? S_DONE : S_LOAD_F;
        S_DONE:   w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_f_start  <= '0;
      r_f_step   <= '0;
      r_phase    <= '0;
      r_n_steps  <= '0;
      r_dwell    <= '0;
      r_cur_freq <= '0;
      r_step_idx <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_IDLE) && cfg_we) begin
        case (cfg_addr)
          A_F_START: r_f_start <= cfg_data;
          A_F_STEP:  r_f_step  <= cfg_data;
          A_N_STEPS: r_n_steps <= cfg_data[CNT_WIDTH-1:0];
          A_DWELL:   r_dwell   <= cfg_data[CNT_WIDTH-1:0];
          A_PHASE:   r_phase   <= cfg_data;
          default:   ;
        endcase
      end
      if (w_launch) begin
        r_cur_freq <= r_f_start;
        r_step_idx <= '0;
      end else if (w_advance) begin
        r_cur_freq <= r_cur_freq + r_f_step;
        r_step_idx <= r_step_idx + CNT_WIDTH'(1);
      end
    end
  end

  assign Enable = (r_state == S_LOAD_P) || (r_state == S_LOAD_F) || (r_state == S_DWELL);
  assign LoadP  = (r_state == S_LOAD_P);
  assign LoadF  = (r_state == S_LOAD_F);
  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);

  always_comb begin
    FreqPhase = '0;
    if (r_state == S_LOAD_P)      FreqPhase = r_phase;
    else if (r_state == S_LOAD_F) FreqPhase = r_cur_freq;
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: sweep timing, wrap, zero dwell/steps,
// abort, busy-time writes/starts and mid-sweep reset.
module tb_dds_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic        start;
  logic        abort;
  logic        Enable;
  logic        LoadP;
  logic        LoadF;
  logic [15:0] FreqPhase;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  int lf_val[$];
  int lf_cyc[$];
  int lp_cyc;
  int lp_val;
  int done_cyc;
  int done_n;
  int en_cnt;
  int busy_cnt;
  int fp_bad;
  int idle_after;
  int snap;

  dds_sweep_ctrl #(.DATA_WIDTH(16), .CNT_WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .start     (start),
    .abort     (abort),
    .Enable    (Enable),
    .LoadP     (LoadP),
    .LoadF     (LoadF),
    .FreqPhase (FreqPhase),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfgw(input logic [2:0] a, input logic [15:0] d);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    tick();
    cfg_we   = 1'b0;
  endtask

  // Cycle 0 is the start-sample cycle. ab_c/pk_c/rs_c select a cycle in which
  // abort, a busy-time write+start, or reset(+abort+start+write) is driven.
  task automatic sweep(input int maxc, input int ab_c, input int pk_c, input int rs_c);
    lf_val.delete();
    lf_cyc.delete();
    lp_cyc = -1; lp_val = -1; done_cyc = -1; done_n = 0;
    en_cnt = 0; busy_cnt = 0; fp_bad = 0; idle_after = -1; snap = -1;
    for (int c = 0; c < maxc; c++) begin
      if (LoadP) begin lp_cyc = c; lp_val = int'(FreqPhase); end
      if (LoadF) begin lf_val.push_back(int'(FreqPhase)); lf_cyc.push_back(c); end
      if (done) begin done_n++; if (done_cyc < 0) done_cyc = c; end
      if (Enable) en_cnt++;
      if (busy) busy_cnt++;
      if (!LoadP && !LoadF && FreqPhase != 16'h0) fp_bad++;
      if (done_cyc >= 0 && c == done_cyc + 1) idle_after = int'(busy);
      if (c == rs_c + 1) snap = int'({Enable, LoadP, LoadF, busy, done, FreqPhase});
      start    = (c == 0) || (c == pk_c) || (c == rs_c);
      abort    = (c == ab_c) || (c == rs_c);
      rst      = (c == rs_c);
      cfg_we   = (c == pk_c) || (c == rs_c);
      cfg_addr = 3'd0;
      cfg_data = 16'h7777;
      tick();
    end
    start = 1'b0; abort = 1'b0; rst = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic chk_basic(input string p);
    chk({p, "_lp_cyc"}, lp_cyc, 1);
    chk({p, "_lf_n"}, lf_val.size(), 3);
    if (lf_val.size() == 3) begin
      chk({p, "_lf0"}, lf_val[0], 'h1000);
      chk({p, "_lf0_cyc"}, lf_cyc[0], 2);
      chk({p, "_lf1"}, lf_val[1], 'h1800);
      chk({p, "_lf1_cyc"}, lf_cyc[1], 6);
      chk({p, "_lf2"}, lf_val[2], 'h2000);
      chk({p, "_lf2_cyc"}, lf_cyc[2], 10);
    end
    chk({p, "_done_cyc"}, done_cyc, 14);
    chk({p, "_done_n"}, done_n, 1);
    chk({p, "_idle_after"}, idle_after, 0);
    chk({p, "_en_cnt"}, en_cnt, 13);
    chk({p, "_busy_cnt"}, busy_cnt, 14);
    chk({p, "_fp_zero"}, fp_bad, 0);
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = 3'd0; cfg_data = 16'h0;
    start = 1'b0; abort = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_enable", int'(Enable), 0);
    chk("rst_loadp", int'(LoadP), 0);
    chk("rst_loadf", int'(LoadF), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_fp", int'(FreqPhase), 0);

    // Basic sweep, with a reserved-address write that must be ignored
    cfgw(3'd4, 16'h0000);
    cfgw(3'd0, 16'h1000);
    cfgw(3'd1, 16'h0800);
    cfgw(3'd2, 16'h0002);
    cfgw(3'd3, 16'h0003);
    cfgw(3'd5, 16'hFFFF);
    sweep(20, -1, -1, -1);
    chk_basic("basic");

    // Wrap-around with a nonzero phase
    cfgw(3'd4, 16'hABCD);
    cfgw(3'd0, 16'hF000);
    cfgw(3'd1, 16'h2000);
    cfgw(3'd2, 16'h0001);
    cfgw(3'd3, 16'h0001);
    sweep(12, -1, -1, -1);
    chk("wrap_lp_cyc", lp_cyc, 1);
    chk("wrap_lp_val", lp_val, 'hABCD);
    chk("wrap_lf_n", lf_val.size(), 2);
    if (lf_val.size() == 2) begin
      chk("wrap_lf0", lf_val[0], 'hF000);
      chk("wrap_lf1", lf_val[1], 'h1000);
      chk("wrap_lf1_cyc", lf_cyc[1], 4);
    end
    chk("wrap_done_cyc", done_cyc, 6);
    chk("wrap_en_cnt", en_cnt, 5);
    chk("wrap_busy_cnt", busy_cnt, 6);

    // Zero dwell, zero extra steps
    cfgw(3'd4, 16'h0000);
    cfgw(3'd0, 16'h0555);
    cfgw(3'd2, 16'h0000);
    cfgw(3'd3, 16'h0000);
    sweep(10, -1, -1, -1);
    chk("zero_lf_n", lf_val.size(), 1);
    if (lf_val.size() == 1) chk("zero_lf0", lf_val[0], 'h0555);
    chk("zero_done_cyc", done_cyc, 4);
    chk("zero_en_cnt", en_cnt, 3);

    // Abort in the second dwell (cycles 7..9), then replay
    cfgw(3'd0, 16'h1000);
    cfgw(3'd1, 16'h0800);
    cfgw(3'd2, 16'h0002);
    cfgw(3'd3, 16'h0003);
    sweep(20, 8, -1, -1);
    chk("abort_done_n", done_n, 0);
    chk("abort_en_cnt", en_cnt, 8);
    chk("abort_busy_cnt", busy_cnt, 8);
    chk("abort_lf_n", lf_val.size(), 2);
    sweep(20, -1, -1, -1);
    chk_basic("replay");

    // Write and start while busy must not disturb the sweep or f_start
    sweep(20, -1, 3, -1);
    chk_basic("busywr");
    sweep(20, -1, -1, -1);
    chk("busywr_next_lf0", (lf_val.size() > 0) ? lf_val[0] : -1, 'h1000);

    // Reset in cycle 7 alongside abort/start/write; reset wins
    sweep(15, -1, -1, 7);
    chk("rstmid_snap", snap, 0);
    chk("rstmid_done_n", done_n, 0);
    chk("rstmid_lf_n", lf_val.size(), 2);
    chk("rstmid_busy_cnt", busy_cnt, 7);
    sweep(10, -1, -1, -1);
    chk("postrst_lf_n", lf_val.size(), 1);
    if (lf_val.size() == 1) chk("postrst_lf0", lf_val[0], 0);
    chk("postrst_done_cyc", done_cyc, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
